// File: rtl/wb_trace_checker_pkg.sv
// Shared types and helpers for the writeback trace checker.
package wb_trace_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int ERR_W = 8;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wb_trace_checker_if.sv
// Expected-entry load port, control pulses, writeback snoop and verdict bundle.
interface wb_trace_checker_if
  import wb_trace_checker_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 16
);
  localparam int IW = $clog2(DEPTH) + 1;

  logic              exp_valid;
  logic              exp_ready;
  logic [REG_AW-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              arm;
  logic              clear;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              busy;
  logic              done;
  logic              pass;
  logic              fail;
  logic              timeout;
  logic [ERR_W-1:0]  err_count;
  logic [IW-1:0]     fail_index;
  logic [REG_AW-1:0] fail_addr;
  logic [DATA_W-1:0] fail_got;
  logic [DATA_W-1:0] fail_exp;

  modport slave (
    input  exp_valid, exp_addr, exp_data, arm, clear, wb_en, wb_addr, wb_data,
    output exp_ready, busy, done, pass, fail, timeout, err_count,
           fail_index, fail_addr, fail_got, fail_exp
  );

  modport master (
    output exp_valid, exp_addr, exp_data, arm, clear, wb_en, wb_addr, wb_data,
    input  exp_ready, busy, done, pass, fail, timeout, err_count,
           fail_index, fail_addr, fail_got, fail_exp
  );
endinterface

// File: rtl/wb_trace_checker_sync_fifo.sv
// Single-clock FIFO holding expected (register, value) entries; head is the oldest entry.
module sync_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [W-1:0]           o_head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/wb_trace_checker.sv
// In-order writeback checker against a preloaded expected queue, with stall timeout.
// state | meaning: IDLE load queue | RUN pop and compare each writeback | DONE verdict held, overruns counted
module wb_trace_checker
  import wb_trace_checker_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter int DEPTH        = 16,
  parameter int TIMEOUT      = 64,
  parameter int IGNORE_R0    = 1,
  parameter int STOP_ON_FAIL = 0
) (
  input logic               i_clk,
  input logic               i_rst,
  wb_trace_checker_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = AW + 1;
  localparam int EW = REG_AW + DATA_W;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  state_e            r_state, w_state_nxt;
  logic [TW-1:0]     r_tmr, w_tmr_nxt;
  logic [IW-1:0]     r_ord, w_ord_nxt, w_ord_inc;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_pass, w_pass_nxt;
  logic              r_fail, w_fail_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic [ERR_W-1:0]  r_err, w_err_nxt;
  logic [IW-1:0]     r_fidx, w_fidx_nxt;
  logic [REG_AW-1:0] r_faddr, w_faddr_nxt;
  logic [DATA_W-1:0] r_fgot, w_fgot_nxt;
  logic [DATA_W-1:0] r_fexp, w_fexp_nxt;

  logic              w_full, w_empty, w_push, w_pop, w_fifo_rst;
  logic [AW:0]       w_count;
  logic [EW-1:0]     w_head;
  logic [REG_AW-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_qual, w_mism, w_exp_ready;

  assign w_exp_ready = i_rst & (r_state == ST_IDLE) & ~w_full;
  assign w_push      = bus.exp_valid & w_exp_ready;
  assign w_fifo_rst  = i_rst & ~bus.clear;
  assign w_head_addr = w_head[EW-1:DATA_W];
  assign w_head_data = w_head[DATA_W-1:0];
  assign w_qual      = bus.wb_en & ~((IGNORE_R0 != 0) && (bus.wb_addr == '0));
  assign w_mism      = (bus.wb_addr != w_head_addr) || (bus.wb_data != w_head_data);
  assign w_ord_inc   = (r_ord == '1) ? r_ord : r_ord + 1'b1;

  sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (w_fifo_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({bus.exp_addr, bus.exp_data}),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_tmr_nxt     = r_tmr;
    w_ord_nxt     = r_ord;
    w_done_nxt    = r_done;
    w_pass_nxt    = r_pass;
    w_fail_nxt    = r_fail;
    w_timeout_nxt = r_timeout;
    w_err_nxt     = r_err;
    w_fidx_nxt    = r_fidx;
    w_faddr_nxt   = r_faddr;
    w_fgot_nxt    = r_fgot;
    w_fexp_nxt    = r_fexp;
    w_pop         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.arm) begin
          if (w_empty && !w_push) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
            w_tmr_nxt   = TMR_LOAD;
          end
        end
      end
      ST_RUN: begin
        if (w_qual) begin
          w_pop     = 1'b1;
          w_tmr_nxt = TMR_LOAD;
          w_ord_nxt = w_ord_inc;
          if (w_mism) begin
            w_err_nxt  = sat_inc(r_err);
            w_fail_nxt = 1'b1;
            if (!r_fail) begin
              w_fidx_nxt  = r_ord;
              w_faddr_nxt = bus.wb_addr;
              w_fgot_nxt  = bus.wb_data;
              w_fexp_nxt  = w_head_data;
            end
          end
          if ((w_count == (AW+1)'(1)) || ((STOP_ON_FAIL != 0) && w_mism)) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = !(r_fail || w_mism);
          end
        end else if (r_tmr == '0) begin
          w_state_nxt   = ST_DONE;
          w_done_nxt    = 1'b1;
          w_pass_nxt    = 1'b0;
          w_fail_nxt    = 1'b1;
          w_timeout_nxt = 1'b1;
          if (!r_fail) begin
            w_fidx_nxt  = r_ord;
            w_faddr_nxt = w_head_addr;
            w_fgot_nxt  = '0;
            w_fexp_nxt  = w_head_data;
          end
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end
      ST_DONE: begin
        // Any qualifying writeback after the verdict is an overrun.
        if (w_qual) begin
          w_err_nxt  = sat_inc(r_err);
          w_fail_nxt = 1'b1;
          w_pass_nxt = 1'b0;
          w_ord_nxt  = w_ord_inc;
          if (!r_fail) begin
            w_fidx_nxt  = r_ord;
            w_faddr_nxt = bus.wb_addr;
            w_fgot_nxt  = bus.wb_data;
            w_fexp_nxt  = '0;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (bus.clear) begin
      w_state_nxt   = ST_IDLE;
      w_tmr_nxt     = '0;
      w_ord_nxt     = '0;
      w_done_nxt    = 1'b0;
      w_pass_nxt    = 1'b0;
      w_fail_nxt    = 1'b0;
      w_timeout_nxt = 1'b0;
      w_err_nxt     = '0;
      w_fidx_nxt    = '0;
      w_faddr_nxt   = '0;
      w_fgot_nxt    = '0;
      w_fexp_nxt    = '0;
      w_pop         = 1'b0;
    end
    w_busy_nxt = (w_state_nxt == ST_RUN);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= ST_IDLE;
      r_tmr     <= '0;
      r_ord     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
      r_err     <= '0;
      r_fidx    <= '0;
      r_faddr   <= '0;
      r_fgot    <= '0;
      r_fexp    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_ord     <= w_ord_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_pass    <= w_pass_nxt;
      r_fail    <= w_fail_nxt;
      r_timeout <= w_timeout_nxt;
      r_err     <= w_err_nxt;
      r_fidx    <= w_fidx_nxt;
      r_faddr   <= w_faddr_nxt;
      r_fgot    <= w_fgot_nxt;
      r_fexp    <= w_fexp_nxt;
    end
  end

  assign bus.exp_ready  = w_exp_ready;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.pass       = r_pass;
  assign bus.fail       = r_fail;
  assign bus.timeout    = r_timeout;
  assign bus.err_count  = r_err;
  assign bus.fail_index = r_fidx;
  assign bus.fail_addr  = r_faddr;
  assign bus.fail_got   = r_fgot;
  assign bus.fail_exp   = r_fexp;
endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed and randomized bench for wb_trace_checker against a queue-based reference model.
module tb_wb_trace_checker;
  localparam int DATA_W       = 32;
  localparam int REG_AW       = 5;
  localparam int DEPTH        = 16;
  localparam int TIMEOUT      = 4;
  localparam int IGNORE_R0    = 1;
  localparam int STOP_ON_FAIL = 0;
  localparam int IW           = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_trace_checker_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) bus ();

  wb_trace_checker #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT),
    .IGNORE_R0(IGNORE_R0), .STOP_ON_FAIL(STOP_ON_FAIL)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  // Reference model: expected queue plus the verdict the checker should hold.
  ent_t        m_q[$];
  int          m_mode;  // 0 idle, 1 run, 2 done
  int          m_stall, m_err, m_ord, m_fidx;
  bit          m_done, m_pass, m_fail, m_to;
  logic [4:0]  m_faddr;
  logic [31:0] m_fgot, m_fexp;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void model_reset();
    m_q.delete();
    m_mode = 0; m_stall = 0; m_err = 0; m_ord = 0; m_fidx = 0;
    m_done = 0; m_pass = 0; m_fail = 0; m_to = 0;
    m_faddr = '0; m_fgot = '0; m_fexp = '0;
  endfunction

  function automatic void record_err(logic [4:0] a, logic [31:0] got, logic [31:0] exp);
    if (!m_fail) begin
      m_fidx = m_ord; m_faddr = a; m_fgot = got; m_fexp = exp;
    end
    m_fail = 1;
    if (m_err < 255) m_err++;
  endfunction

  function automatic void bump_ord();
    if (m_ord < (1 << IW) - 1) m_ord++;
  endfunction

  function automatic void model_edge();
    bit   qual, mism;
    ent_t h;
    if (!rst || bus.clear) begin
      model_reset();
      return;
    end
    qual = bus.wb_en && !(IGNORE_R0 != 0 && bus.wb_addr == 0);
    case (m_mode)
      0: begin
        if (bus.exp_valid && m_q.size() < DEPTH)
          m_q.push_back('{a: bus.exp_addr, d: bus.exp_data});
        if (bus.arm) begin
          if (m_q.size() == 0) begin m_mode = 2; m_done = 1; m_pass = 1; end
          else begin m_mode = 1; m_stall = 0; end
        end
      end
      1: begin
        if (qual) begin
          h = m_q.pop_front();
          m_stall = 0;
          mism = (h.a != bus.wb_addr) || (h.d != bus.wb_data);
          if (mism) record_err(bus.wb_addr, bus.wb_data, h.d);
          bump_ord();
          if (m_q.size() == 0 || (STOP_ON_FAIL != 0 && mism)) begin
            m_mode = 2; m_done = 1; m_pass = !m_fail;
          end
        end else begin
          m_stall++;
          if (m_stall >= TIMEOUT) begin
            if (!m_fail) begin
              m_fidx = m_ord; m_faddr = m_q[0].a; m_fgot = '0; m_fexp = m_q[0].d;
            end
            m_mode = 2; m_done = 1; m_pass = 0; m_fail = 1; m_to = 1;
          end
        end
      end
      default: begin
        if (qual) begin
          record_err(bus.wb_addr, bus.wb_data, 32'd0);
          m_pass = 0;
          bump_ord();
        end
      end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("exp_ready",  32'(bus.exp_ready),  32'(rst && m_mode == 0 && m_q.size() < DEPTH));
    chk("busy",       32'(bus.busy),       32'(m_mode == 1));
    chk("done",       32'(bus.done),       32'(m_done));
    chk("pass",       32'(bus.pass),       32'(m_pass));
    chk("fail",       32'(bus.fail),       32'(m_fail));
    chk("timeout",    32'(bus.timeout),    32'(m_to));
    chk("err_count",  32'(bus.err_count),  32'(m_err));
    chk("fail_index", 32'(bus.fail_index), 32'(m_fidx));
    chk("fail_addr",  32'(bus.fail_addr),  32'(m_faddr));
    chk("fail_got",   bus.fail_got,        m_fgot);
    chk("fail_exp",   bus.fail_exp,        m_fexp);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    bus.exp_valid = 1'b1; bus.exp_addr = a; bus.exp_data = d;
    step();
    bus.exp_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
    step();
    bus.wb_en = 1'b0;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1; step(); bus.arm = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1; step(); bus.clear = 1'b0;
  endtask

  task automatic preload3();
    push(5'd1, 32'd5);
    push(5'd2, 32'd7);
    push(5'd3, 32'hFFFF_FFFA);
  endtask

  initial begin
    bus.exp_valid = 0; bus.exp_addr = '0; bus.exp_data = '0;
    bus.arm = 0; bus.clear = 0;
    bus.wb_en = 0; bus.wb_addr = '0; bus.wb_data = '0;
    model_reset();

    rst = 1'b0;
    repeat (2) step();
    chk("rst_exp_ready", 32'(bus.exp_ready), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b1;
    step();

    // Matching run, then an overrun writeback.
    preload3();
    pulse_arm();
    chk("t1_busy", 32'(bus.busy), 32'd1);
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd7);
    chk("t1_not_done_yet", 32'(bus.done), 32'd0);
    wb(5'd3, 32'hFFFF_FFFA);
    chk("t1_done", 32'(bus.done), 32'd1);
    chk("t1_pass", 32'(bus.pass), 32'd1);
    chk("t1_err", 32'(bus.err_count), 32'd0);
    wb(5'd7, 32'd3);
    chk("ovr_err", 32'(bus.err_count), 32'd1);
    chk("ovr_pass", 32'(bus.pass), 32'd0);
    chk("ovr_fail", 32'(bus.fail), 32'd1);
    chk("ovr_index", 32'(bus.fail_index), 32'd3);
    chk("ovr_addr", 32'(bus.fail_addr), 32'd7);
    chk("ovr_got", bus.fail_got, 32'd3);
    pulse_clear();
    chk("clr_done", 32'(bus.done), 32'd0);
    chk("clr_err", 32'(bus.err_count), 32'd0);
    chk("clr_fail", 32'(bus.fail), 32'd0);
    chk("clr_ready", 32'(bus.exp_ready), 32'd1);

    // Data mismatch on the second writeback.
    preload3();
    pulse_arm();
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd8);
    chk("t2_fail", 32'(bus.fail), 32'd1);
    chk("t2_index", 32'(bus.fail_index), 32'd1);
    chk("t2_addr", 32'(bus.fail_addr), 32'd2);
    chk("t2_got", bus.fail_got, 32'd8);
    chk("t2_exp", bus.fail_exp, 32'd7);
    chk("t2_err", 32'(bus.err_count), 32'd1);
    chk("t2_done_early", 32'(bus.done), 32'd0);
    wb(5'd3, 32'hFFFF_FFFA);
    chk("t2_done", 32'(bus.done), 32'd1);
    chk("t2_pass", 32'(bus.pass), 32'd0);
    pulse_clear();

    // r0 writes are ignored and do not hold off the stall timer.
    push(5'd4, 32'd9);
    pulse_arm();
    repeat (3) wb(5'd0, 32'h1234);
    chk("t3_busy", 32'(bus.busy), 32'd1);
    chk("t3_noerr", 32'(bus.err_count), 32'd0);
    chk("t3_nofail", 32'(bus.fail), 32'd0);
    step();
    chk("t3_timeout", 32'(bus.timeout), 32'd1);
    chk("t3_fail", 32'(bus.fail), 32'd1);
    chk("t3_done", 32'(bus.done), 32'd1);
    chk("t3_addr", 32'(bus.fail_addr), 32'd4);
    chk("t3_exp", bus.fail_exp, 32'd9);
    chk("t3_got", bus.fail_got, 32'd0);
    pulse_clear();

    // Fill to DEPTH, offer one more, then drain.
    for (int i = 0; i < DEPTH; i++) push(5'(i + 1), 32'(i * 3));
    chk("t4_full_ready", 32'(bus.exp_ready), 32'd0);
    push(5'd31, 32'd999);
    chk("t4_still_full", 32'(bus.exp_ready), 32'd0);
    pulse_arm();
    for (int i = 0; i < DEPTH; i++) wb(5'(i + 1), 32'(i * 3));
    chk("t4_done", 32'(bus.done), 32'd1);
    chk("t4_pass", 32'(bus.pass), 32'd1);
    pulse_clear();
    pulse_arm();
    chk("empty_done", 32'(bus.done), 32'd1);
    chk("empty_pass", 32'(bus.pass), 32'd1);
    pulse_clear();

    // Reset in the middle of a run flushes everything.
    preload3();
    pulse_arm();
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd7);
    rst = 1'b0;
    step();
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_ready", 32'(bus.exp_ready), 32'd0);
    rst = 1'b1;
    step();
    pulse_arm();
    chk("t5_empty_done", 32'(bus.done), 32'd1);
    chk("t5_empty_pass", 32'(bus.pass), 32'd1);

    // Randomized runs.
    for (int r = 0; r < 60; r++) begin
      int n;
      bit armed;
      pulse_clear();
      n = $urandom_range(0, DEPTH + 2);
      armed = 0;
      for (int i = 0; i < n; i++) begin
        bus.exp_valid = ($urandom_range(0, 3) != 0);
        bus.exp_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.exp_data  = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($urandom_range(0, 15));
        bus.arm       = (i == n - 1) && ($urandom_range(0, 2) == 0);
        if (bus.arm) armed = 1;
        step();
      end
      bus.exp_valid = 0;
      bus.arm = 0;
      if (!armed) pulse_arm();
      for (int c = 0; c < 3 * DEPTH + 12; c++) begin
        int k;
        k = $urandom_range(0, 19);
        bus.wb_en = 1'b1;
        if (k < 3) begin
          bus.wb_en = 1'b0;
        end else if (k < 5) begin
          bus.wb_addr = 5'd0; bus.wb_data = 32'($urandom);
        end else if (k < 7 || m_q.size() == 0) begin
          bus.wb_addr = 5'($urandom_range(1, 31)); bus.wb_data = 32'($urandom);
        end else begin
          bus.wb_addr = m_q[0].a; bus.wb_data = m_q[0].d;
        end
        bus.exp_valid = ($urandom_range(0, 3) == 0);
        bus.arm   = ($urandom_range(0, 30) == 0);
        bus.clear = ($urandom_range(0, 200) == 0);
        rst       = ($urandom_range(0, 300) != 0);
        step();
        bus.arm = 0; bus.clear = 0; rst = 1'b1; bus.exp_valid = 0;
        if (m_mode == 0) break;
        if (m_mode == 2 && $urandom_range(0, 5) == 0) break;
      end
      bus.wb_en = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
